// File: rtl/iob_fifo_sync_asym_pkg.sv
// Shared width helpers for the asymmetric FIFO and its RAM: max/min of the two
// data widths and the address width of each RAM port, so the FIFO and the RAM
// instance derive identical port geometries.
package iob_fifo_sync_asym_pkg;

    function automatic int iob_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int iob_min(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // The wider port addresses fewer, larger words: it loses log2(ratio)
    // address bits. The narrower port uses the full ADDR_W.
    function automatic int port_addr_w(input int data_w, input int other_w, input int addr_w);
        return (data_w > other_w) ? addr_w - $clog2(data_w / other_w) : addr_w;
    endfunction

endpackage

// File: rtl/iob_fifo_sync_asym_if.sv
// Producer/consumer side of the asymmetric FIFO. The master modport is the
// user (producer + consumer); the slave modport is the FIFO itself.
// IOB_FIFO_ERR_EN adds err_clr and the sticky overflow/underflow flags.
interface iob_fifo_sync_asym_if #(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 8,
    parameter int ADDR_W   = 6
) ();
    logic                w_en;
    logic [W_DATA_W-1:0] w_data;
    logic                w_full;
    logic                r_en;
    logic [R_DATA_W-1:0] r_data;
    logic                r_valid;
    logic                r_empty;
    logic [ADDR_W:0]     level;
`ifdef IOB_FIFO_ERR_EN
    logic                err_clr;
    logic                w_overflow;
    logic                r_underflow;

    modport master (
        output w_en, w_data, r_en, err_clr,
        input  w_full, r_data, r_valid, r_empty, level, w_overflow, r_underflow
    );
    modport slave (
        input  w_en, w_data, r_en, err_clr,
        output w_full, r_data, r_valid, r_empty, level, w_overflow, r_underflow
    );
`else
    modport master (
        output w_en, w_data, r_en,
        input  w_full, r_data, r_valid, r_empty, level
    );
    modport slave (
        input  w_en, w_data, r_en,
        output w_full, r_data, r_valid, r_empty, level
    );
`endif
endinterface

// File: rtl/iob_fifo_level.sv
// Occupancy counter for a FIFO whose write and read sides move different
// amounts of data per access. Level is counted in narrow-word units; the
// full/empty flags and request acceptance derive from the registered level
// only, so a same-cycle access on the other side never bypasses a flag.
module iob_fifo_level #(
    parameter int ADDR_W = 6,
    parameter int W_INCR = 4,
    parameter int R_INCR = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            w_en,
    input  logic            r_en,
    output logic            w_acc,
    output logic            r_acc,
    output logic [ADDR_W:0] level,
    output logic            w_full,
    output logic            r_empty
);
    localparam logic [ADDR_W:0] CAPACITY    = (ADDR_W+1)'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] W_INCR_L    = (ADDR_W+1)'(W_INCR);
    localparam logic [ADDR_W:0] R_INCR_L    = (ADDR_W+1)'(R_INCR);
    localparam logic [ADDR_W:0] FULL_THRESH = CAPACITY - W_INCR_L;

    logic [ADDR_W:0] level_reg;
    logic [ADDR_W:0] level_next;

    assign w_full  = level_reg > FULL_THRESH;
    assign r_empty = level_reg < R_INCR_L;
    // Reset also suppresses acceptance so no RAM access escapes that cycle.
    assign w_acc   = rst_n & w_en & ~w_full;
    assign r_acc   = rst_n & r_en & ~r_empty;
    assign level   = level_reg;

    // Apply both sides in one step; the flags guarantee no wrap in either direction.
    always_comb begin
        level_next = level_reg;
        if (w_acc) level_next = level_next + W_INCR_L;
        if (r_acc) level_next = level_next - R_INCR_L;
    end

    // Register the occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) level_reg <= '0;
        else        level_reg <= level_next;
    end
endmodule

// File: rtl/iob_fifo_sync_asym.sv
// Synchronous FIFO controller driving an external asymmetric dual-port RAM as
// a circular buffer. Owns both pointers, the fill level and the flags; the
// RAM provides one-cycle read latency, forwarded to the consumer as r_valid.
// Optional build macro: IOB_FIFO_ERR_EN (sticky overflow/underflow flags).
module iob_fifo_sync_asym
    import iob_fifo_sync_asym_pkg::*;
#(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 8,
    parameter int ADDR_W   = 6,
    parameter int W_ADDR_W = port_addr_w(W_DATA_W, R_DATA_W, ADDR_W),
    parameter int R_ADDR_W = port_addr_w(R_DATA_W, W_DATA_W, ADDR_W)
) (
    input  logic                clk,
    input  logic                rst_n,
    iob_fifo_sync_asym_if.slave fifo_if,
    output logic                ram_w_en,
    output logic [W_ADDR_W-1:0] ram_w_addr,
    output logic [W_DATA_W-1:0] ram_w_data,
    output logic                ram_r_en,
    output logic [R_ADDR_W-1:0] ram_r_addr,
    input  logic [R_DATA_W-1:0] ram_r_data
);
    localparam int MINDATA_W = iob_min(W_DATA_W, R_DATA_W);
    localparam int W_INCR    = W_DATA_W / MINDATA_W;
    localparam int R_INCR    = R_DATA_W / MINDATA_W;

    logic                w_acc;
    logic                r_acc;
    logic                w_full;
    logic                r_empty;
    logic [W_ADDR_W-1:0] w_ptr_reg;
    logic [R_ADDR_W-1:0] r_ptr_reg;
    logic                r_valid_reg;

    iob_fifo_level #(
        .ADDR_W (ADDR_W),
        .W_INCR (W_INCR),
        .R_INCR (R_INCR)
    ) u_level (
        .clk     (clk),
        .rst_n   (rst_n),
        .w_en    (fifo_if.w_en),
        .r_en    (fifo_if.r_en),
        .w_acc   (w_acc),
        .r_acc   (r_acc),
        .level   (fifo_if.level),
        .w_full  (w_full),
        .r_empty (r_empty)
    );

    assign fifo_if.w_full  = w_full;
    assign fifo_if.r_empty = r_empty;
    assign fifo_if.r_valid = r_valid_reg;
    assign fifo_if.r_data  = ram_r_data;

    assign ram_w_en   = w_acc;
    assign ram_w_addr = w_ptr_reg;
    assign ram_w_data = fifo_if.w_data;
    assign ram_r_en   = r_acc;
    assign ram_r_addr = r_ptr_reg;

    // Pointers wrap naturally at their port width; r_valid tracks RAM read latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_ptr_reg   <= '0;
            r_ptr_reg   <= '0;
            r_valid_reg <= 1'b0;
        end else begin
            if (w_acc) w_ptr_reg <= w_ptr_reg + W_ADDR_W'(1);
            if (r_acc) r_ptr_reg <= r_ptr_reg + R_ADDR_W'(1);
            r_valid_reg <= r_acc;
        end
    end

`ifdef IOB_FIFO_ERR_EN
    logic w_overflow_reg;
    logic r_underflow_reg;

    // Sticky rejection flags; a new rejection outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_overflow_reg  <= 1'b0;
            r_underflow_reg <= 1'b0;
        end else begin
            if (fifo_if.w_en && w_full)       w_overflow_reg <= 1'b1;
            else if (fifo_if.err_clr)         w_overflow_reg <= 1'b0;
            if (fifo_if.r_en && r_empty)      r_underflow_reg <= 1'b1;
            else if (fifo_if.err_clr)         r_underflow_reg <= 1'b0;
        end
    end

    assign fifo_if.w_overflow  = w_overflow_reg;
    assign fifo_if.r_underflow = r_underflow_reg;
`endif
endmodule

// File: tb/tb_iob_fifo_sync_asym.sv
// Bench for iob_fifo_sync_asym: a 32->8 instance and an 8->32 instance, each
// attached to a behavioural asymmetric RAM. Expected read data is queued when
// writes are issued and popped when r_valid appears.
module tb_iob_fifo_sync_asym;
    import iob_fifo_sync_asym_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- instance A: write 32, read 8, 64 bytes ----------------
    iob_fifo_sync_asym_if #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(6)) ifa ();
    logic        ram_w_en_a;
    logic [3:0]  ram_w_addr_a;
    logic [31:0] ram_w_data_a;
    logic        ram_r_en_a;
    logic [5:0]  ram_r_addr_a;
    logic [7:0]  ram_r_data_a;

    iob_fifo_sync_asym #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(6)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_if    (ifa),
        .ram_w_en   (ram_w_en_a),
        .ram_w_addr (ram_w_addr_a),
        .ram_w_data (ram_w_data_a),
        .ram_r_en   (ram_r_en_a),
        .ram_r_addr (ram_r_addr_a),
        .ram_r_data (ram_r_data_a)
    );

    logic [7:0] mem_a [64];
    logic [7:0] rd_a;
    always @(posedge clk) begin
        if (ram_w_en_a)
            for (int k = 0; k < 4; k++) mem_a[int'(ram_w_addr_a) * 4 + k] <= ram_w_data_a[k*8 +: 8];
        if (ram_r_en_a) rd_a <= mem_a[ram_r_addr_a];
    end
    assign ram_r_data_a = rd_a;

    // ---------------- instance B: write 8, read 32, 16 bytes ----------------
    iob_fifo_sync_asym_if #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) ifb ();
    logic        ram_w_en_b;
    logic [3:0]  ram_w_addr_b;
    logic [7:0]  ram_w_data_b;
    logic        ram_r_en_b;
    logic [1:0]  ram_r_addr_b;
    logic [31:0] ram_r_data_b;

    iob_fifo_sync_asym #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_if    (ifb),
        .ram_w_en   (ram_w_en_b),
        .ram_w_addr (ram_w_addr_b),
        .ram_w_data (ram_w_data_b),
        .ram_r_en   (ram_r_en_b),
        .ram_r_addr (ram_r_addr_b),
        .ram_r_data (ram_r_data_b)
    );

    logic [7:0]  mem_b [16];
    logic [31:0] rd_b;
    always @(posedge clk) begin
        if (ram_w_en_b) mem_b[ram_w_addr_b] <= ram_w_data_b;
        if (ram_r_en_b)
            rd_b <= {mem_b[int'(ram_r_addr_b)*4+3], mem_b[int'(ram_r_addr_b)*4+2],
                     mem_b[int'(ram_r_addr_b)*4+1], mem_b[int'(ram_r_addr_b)*4]};
    end
    assign ram_r_data_b = rd_b;

    // ---------------- scoreboard state ----------------
    logic [7:0]  qa [$];
    logic [31:0] qb [$];
    int          wpa = 0, rpa = 0, wpb = 0, rpb = 0;
    logic [31:0] acc_b = '0;
    int          nb = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Consumer side: every r_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ifa.r_valid === 1'b1) begin
            chk("a_rvalid_has_expect", {31'b0, qa.size() != 0}, 32'd1);
            if (qa.size() != 0) begin
                logic [7:0] e;
                e = qa.pop_front();
                $display("A read  data=%02h expect=%02h", ifa.r_data, e);
                chk("a_r_data", {24'b0, ifa.r_data}, {24'b0, e});
            end
        end
        if (ifb.r_valid === 1'b1) begin
            chk("b_rvalid_has_expect", {31'b0, qb.size() != 0}, 32'd1);
            if (qb.size() != 0) begin
                logic [31:0] e;
                e = qb.pop_front();
                $display("B read  data=%08h expect=%08h", ifb.r_data, e);
                chk("b_r_data", ifb.r_data, e);
            end
        end
    end

    // One cycle of requests on A with the acceptance the bench expects.
    task automatic op_a(input bit we, input logic [31:0] d, input bit re, input bit w_ok, input bit r_ok);
        @(negedge clk);
        ifa.w_en = we; ifa.w_data = d; ifa.r_en = re;
        #1;
        chk("a_ram_w_en", {31'b0, ram_w_en_a}, {31'b0, w_ok});
        chk("a_ram_r_en", {31'b0, ram_r_en_a}, {31'b0, r_ok});
        if (w_ok) begin
            chk("a_ram_w_addr", {28'b0, ram_w_addr_a}, wpa);
            chk("a_ram_w_data", ram_w_data_a, d);
            for (int k = 0; k < 4; k++) qa.push_back(d[k*8 +: 8]);
            wpa = (wpa + 1) % 16;
        end
        if (r_ok) begin
            chk("a_ram_r_addr", {26'b0, ram_r_addr_a}, rpa);
            rpa = (rpa + 1) % 64;
        end
        $display("A op    we=%0d re=%0d data=%08h w_acc=%0d r_acc=%0d", we, re, d, w_ok, r_ok);
        @(posedge clk); #1;
        ifa.w_en = 1'b0; ifa.r_en = 1'b0;
    endtask

    task automatic op_b(input bit we, input logic [7:0] d, input bit re, input bit w_ok, input bit r_ok);
        @(negedge clk);
        ifb.w_en = we; ifb.w_data = d; ifb.r_en = re;
        #1;
        chk("b_ram_w_en", {31'b0, ram_w_en_b}, {31'b0, w_ok});
        chk("b_ram_r_en", {31'b0, ram_r_en_b}, {31'b0, r_ok});
        if (w_ok) begin
            chk("b_ram_w_addr", {28'b0, ram_w_addr_b}, wpb);
            acc_b[nb*8 +: 8] = d;
            nb++;
            if (nb == 4) begin
                qb.push_back(acc_b);
                nb = 0;
            end
            wpb = (wpb + 1) % 16;
        end
        if (r_ok) begin
            chk("b_ram_r_addr", {30'b0, ram_r_addr_b}, rpb);
            rpb = (rpb + 1) % 4;
        end
        $display("B op    we=%0d re=%0d data=%02h w_acc=%0d r_acc=%0d", we, re, d, w_ok, r_ok);
        @(posedge clk); #1;
        ifb.w_en = 1'b0; ifb.r_en = 1'b0;
    endtask

    task automatic lvl_a(input int lv, input bit full, input bit empty);
        chk("a_level",   {25'b0, ifa.level}, lv);
        chk("a_w_full",  {31'b0, ifa.w_full}, {31'b0, full});
        chk("a_r_empty", {31'b0, ifa.r_empty}, {31'b0, empty});
    endtask

    task automatic lvl_b(input int lv, input bit full, input bit empty);
        chk("b_level",   {27'b0, ifb.level}, lv);
        chk("b_w_full",  {31'b0, ifb.w_full}, {31'b0, full});
        chk("b_r_empty", {31'b0, ifb.r_empty}, {31'b0, empty});
    endtask

    initial begin
        ifa.w_en = 1'b0; ifa.w_data = '0; ifa.r_en = 1'b0;
        ifb.w_en = 1'b0; ifb.w_data = '0; ifb.r_en = 1'b0;
`ifdef IOB_FIFO_ERR_EN
        ifa.err_clr = 1'b0; ifb.err_clr = 1'b0;
`endif
        // Reset held with a write request pending: reset must win.
        rst_n = 1'b0;
        ifa.w_en = 1'b1; ifa.w_data = 32'hDEADBEEF;
        ifb.w_en = 1'b1; ifb.w_data = 8'h5A;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_a_ram_w_en", {31'b0, ram_w_en_a}, 32'd0);
        chk("rst_b_ram_w_en", {31'b0, ram_w_en_b}, 32'd0);
        chk("rst_a_r_valid",  {31'b0, ifa.r_valid}, 32'd0);
        lvl_a(0, 1'b0, 1'b1);
        lvl_b(0, 1'b0, 1'b1);
        ifa.w_en = 1'b0; ifb.w_en = 1'b0;
        rst_n = 1'b1;

        // Width down: one 32-bit word comes back as four bytes, low lane first.
        op_a(1'b1, 32'h44332211, 1'b0, 1'b1, 1'b0);
        lvl_a(4, 1'b0, 1'b0);
        repeat (4) op_a(1'b0, '0, 1'b1, 1'b0, 1'b1);
        lvl_a(0, 1'b0, 1'b1);

        // Read while empty is dropped.
        op_a(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("a_empty_read_r_valid", {31'b0, ifa.r_valid}, 32'd0);
`ifdef IOB_FIFO_ERR_EN
        chk("a_r_underflow_set", {31'b0, ifa.r_underflow}, 32'd1);
        @(negedge clk); ifa.err_clr = 1'b1; @(posedge clk); #1; ifa.err_clr = 1'b0;
        chk("a_r_underflow_clr", {31'b0, ifa.r_underflow}, 32'd0);
`endif

        // Fill to capacity, then one write too many.
        for (int i = 0; i < 16; i++) op_a(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
        lvl_a(64, 1'b1, 1'b0);
        op_a(1'b1, 32'hBADBAD00, 1'b0, 1'b0, 1'b0);
        lvl_a(64, 1'b1, 1'b0);
`ifdef IOB_FIFO_ERR_EN
        chk("a_w_overflow_set", {31'b0, ifa.w_overflow}, 32'd1);
        @(negedge clk); ifa.err_clr = 1'b1; @(posedge clk); #1; ifa.err_clr = 1'b0;
        chk("a_w_overflow_clr", {31'b0, ifa.w_overflow}, 32'd0);
`endif
        // Full: the write is refused even though a read is accepted alongside it.
        op_a(1'b1, 32'hBADBAD01, 1'b1, 1'b0, 1'b1);
        lvl_a(63, 1'b1, 1'b0);

        // Drain to level 8, then a simultaneous read+write.
        repeat (55) op_a(1'b0, '0, 1'b1, 1'b0, 1'b1);
        lvl_a(8, 1'b0, 1'b0);
        op_a(1'b1, 32'hA4A3A2A1, 1'b1, 1'b1, 1'b1);
        lvl_a(11, 1'b0, 1'b0);
        repeat (11) op_a(1'b0, '0, 1'b1, 1'b0, 1'b1);
        lvl_a(0, 1'b0, 1'b1);

        // Width up: three bytes are not yet a readable word, the fourth is.
        op_b(1'b1, 8'hB0, 1'b0, 1'b1, 1'b0);
        op_b(1'b1, 8'hB1, 1'b0, 1'b1, 1'b0);
        op_b(1'b1, 8'hB2, 1'b0, 1'b1, 1'b0);
        lvl_b(3, 1'b0, 1'b1);
        op_b(1'b0, '0, 1'b1, 1'b0, 1'b0);
        op_b(1'b1, 8'hB3, 1'b0, 1'b1, 1'b0);
        lvl_b(4, 1'b0, 1'b0);
        op_b(1'b0, '0, 1'b1, 1'b0, 1'b1);
        lvl_b(0, 1'b0, 1'b1);

        // Forty more bytes through a sixteen-byte buffer: both pointers wrap.
        for (int g = 0; g < 10; g++) begin
            for (int j = 0; j < 4; j++) op_b(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
            op_b(1'b0, '0, 1'b1, 1'b0, 1'b1);
        end
        lvl_b(0, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        chk("a_queue_drained", qa.size(), 32'd0);
        chk("b_queue_drained", qb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
